// File: rtl/calc_rx_pkg.sv
// rtl/calc_rx_pkg.sv - shared types and defaults for the calculator result receiver
package calc_rx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_e;

    localparam int DATA_W_DEF = 16;
    localparam int NIB_W_DEF  = 4;
    localparam int STATS_W    = 16;

endpackage

// File: rtl/calc_result_rx_if.sv
// rtl/calc_result_rx_if.sv - valid/ready result hand-off between receiver and consumer
interface calc_result_rx_if #(
    parameter int DATA_W = calc_rx_pkg::DATA_W_DEF
);
    logic [DATA_W-1:0] Result;
    logic              ResultValid;
    logic              ResultReady;

    modport master (output Result, output ResultValid, input ResultReady);
    modport slave  (input Result, input ResultValid, output ResultReady);
endinterface

// File: rtl/calc_rx_edge.sv
// rtl/calc_rx_edge.sv - rising-edge detector for the ClkTx strobe, sampled as data in the Clk domain
module calc_rx_edge (
    input  logic Clk,
    input  logic Reset,
    input  logic ClkTx,
    output logic TxRise
);
    logic clk_tx_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) clk_tx_q <= 1'b0;
        else       clk_tx_q <= ClkTx;
    end

    // Delayed copy resets low so a strobe already high at reset release counts as a rise
    assign TxRise = ClkTx & ~clk_tx_q;
endmodule

// File: rtl/calc_result_rx.sv
// rtl/calc_result_rx.sv - nibble deserializer with one-entry result buffer; CALC_RX_STATS_EN adds word/error counters
module calc_result_rx
    import calc_rx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NIB_W  = NIB_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ClkTx,
    input  logic             DOutValid,
    input  logic [NIB_W-1:0] DataOut,
    calc_result_rx_if.master res,
    output logic             RxBusy,
    output logic             FrameErr,
    output logic             Overrun
`ifdef CALC_RX_STATS_EN
    ,
    output logic [STATS_W-1:0] WordCnt,
    output logic [STATS_W-1:0] ErrCnt
`endif
);
    localparam int NNIB  = DATA_W / NIB_W;
    localparam int CNT_W = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NNIB - 1);

    rx_state_e         state, state_nx;
    logic [CNT_W-1:0]  nib_cnt, nib_cnt_nx;
    logic [DATA_W-1:0] shift, shift_nx;
    logic              tx_rise;
    logic              word_done;
    logic              frame_err_nx;
    logic              accept;
    logic              overrun_nx;

    calc_rx_edge u_edge (
        .Clk    (Clk),
        .Reset  (Reset),
        .ClkTx  (ClkTx),
        .TxRise (tx_rise)
    );

    always_comb begin
        state_nx     = state;
        nib_cnt_nx   = nib_cnt;
        shift_nx     = shift;
        word_done    = 1'b0;
        frame_err_nx = 1'b0;
        if (tx_rise) begin
            case (state)
                IDLE: begin
                    if (DOutValid) begin
                        shift_nx = DATA_W'(DataOut);
                        if (NNIB == 1) begin
                            word_done = 1'b1;
                        end else begin
                            nib_cnt_nx = CNT_W'(1);
                            state_nx   = RECV;
                        end
                    end
                end
                RECV: begin
                    if (DOutValid) begin
                        shift_nx = (shift << NIB_W) | DATA_W'(DataOut);
                        if (nib_cnt == LAST_NIB) begin
                            word_done  = 1'b1;
                            state_nx   = IDLE;
                            nib_cnt_nx = '0;
                        end else begin
                            nib_cnt_nx = nib_cnt + CNT_W'(1);
                        end
                    end else begin
                        frame_err_nx = 1'b1;
                        state_nx     = IDLE;
                        nib_cnt_nx   = '0;
                    end
                end
                default: begin
                    state_nx   = IDLE;
                    nib_cnt_nx = '0;
                end
            endcase
        end
    end

    // A completing word may take the slot the consumer is draining this same cycle
    assign accept     = word_done & (~res.ResultValid | res.ResultReady);
    assign overrun_nx = word_done & ~accept;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state           <= IDLE;
            nib_cnt         <= '0;
            shift           <= '0;
            FrameErr        <= 1'b0;
            Overrun         <= 1'b0;
            res.Result      <= '0;
            res.ResultValid <= 1'b0;
        end else begin
            state    <= state_nx;
            nib_cnt  <= nib_cnt_nx;
            shift    <= shift_nx;
            FrameErr <= frame_err_nx;
            Overrun  <= overrun_nx;
            if (accept) begin
                res.Result      <= shift_nx;
                res.ResultValid <= 1'b1;
            end else if (res.ResultValid & res.ResultReady) begin
                res.ResultValid <= 1'b0;
            end
        end
    end

    assign RxBusy = (state == RECV);

`ifdef CALC_RX_STATS_EN
    logic [1:0]         err_inc;
    logic [STATS_W:0]   err_sum;

    assign err_inc = {1'b0, frame_err_nx} + {1'b0, overrun_nx};
    assign err_sum = {1'b0, ErrCnt} + (STATS_W + 1)'(err_inc);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            WordCnt <= '0;
            ErrCnt  <= '0;
        end else begin
            if (accept && (WordCnt != '1)) WordCnt <= WordCnt + STATS_W'(1);
            ErrCnt <= err_sum[STATS_W] ? '1 : err_sum[STATS_W-1:0];
        end
    end
`endif
endmodule
